// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: instruction field positions, major opcodes
// and the fetch-unit FSM state encoding.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;

  localparam int unsigned OPC_HI  = 31;
  localparam int unsigned OPC_LO  = 26;
  localparam int unsigned FUNC_HI = 5;
  localparam int unsigned FUNC_LO = 0;
  localparam int unsigned IMM_HI  = 15;
  localparam int unsigned IMM_LO  = 0;

  typedef enum logic [1:0] {
    IFU_IDLE,
    IFU_REQ,
    IFU_VALID
  } ifu_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: sequential PC+4 or BEQ target (PC+4 + sext(imm16)<<2).
// All math is modulo 2^ADDR_W.
//  pc_i        current PC
//  imm16_i     branch offset field of the instruction
//  take_i      select branch target instead of PC+4
//  pc_plus4_o  pc_i + 4
//  pc_next_o   selected next PC
module pc_next_calc #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [15:0]       imm16_i,
  input  logic              take_i,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic [ADDR_W-1:0] pc_next_o
);

  logic [ADDR_W-1:0] offset;

  always_comb begin
    offset     = {{(ADDR_W - 18){imm16_i[15]}}, imm16_i, 2'b00};
    pc_plus4_o = pc_i + ADDR_W'(4);
    pc_next_o  = take_i ? (pc_plus4_o + offset) : pc_plus4_o;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequences the PC, fetches words over a req/ack
// handshake and holds each word for the decoder until it is consumed.
//  clk, rst_n            clock, async active-low reset
//  imem_req_o/addr_o     fetch request and word address (= pc)
//  imem_ack_i/rdata_i    memory response
//  instr_valid_o/ready_i decoder handshake; retire = valid & ready
//  instr_o, op_code_o, func_o, pc_o, pc_plus4_o  held instruction and its PC
//  pc_src_i              branch taken, sampled only on retire
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [5:0]         op_code_o,
  output logic [5:0]         func_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  pc_plus4_o,
  input  logic               pc_src_i
);

  ifu_state_e         state_q;
  logic               req_q;
  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_next;
  logic               retire;
  logic               take;

  assign retire = (state_q == IFU_VALID) && instr_ready_i;
  // Gate pc_src so an undriven/X value outside retire never touches the adder select.
  assign take   = retire && pc_src_i;

  pc_next_calc #(
    .ADDR_W (ADDR_W)
  ) u_pc_next_calc (
    .pc_i       (pc_q),
    .imm16_i    (instr_q[IMM_HI:IMM_LO]),
    .take_i     (take),
    .pc_plus4_o (pc_plus4_o),
    .pc_next_o  (pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IFU_IDLE;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= RESET_PC;
    end else begin
      case (state_q)
        IFU_IDLE: begin
          state_q <= IFU_REQ;
          req_q   <= 1'b1;
        end
        IFU_REQ: begin
          if (imem_ack_i) begin
            instr_q <= imem_rdata_i;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= IFU_VALID;
          end
        end
        IFU_VALID: begin
          if (retire) begin
            pc_q    <= pc_next;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= IFU_REQ;
          end
        end
        default: begin
          state_q <= IFU_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign op_code_o     = instr_q[OPC_HI:OPC_LO];
  assign func_o        = instr_q[FUNC_HI:FUNC_LO];
  assign pc_o          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req    [2];
  logic [31:0] addr   [2];
  logic        ack    [2];
  logic [31:0] rdata  [2];
  logic        valid  [2];
  logic        ready  [2];
  logic [31:0] instr  [2];
  logic [5:0]  opc    [2];
  logic [5:0]  func   [2];
  logic [31:0] pc     [2];
  logic [31:0] pcp4   [2];
  logic        pc_src [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (req[0]),
    .imem_addr_o   (addr[0]),
    .imem_ack_i    (ack[0]),
    .imem_rdata_i  (rdata[0]),
    .instr_valid_o (valid[0]),
    .instr_ready_i (ready[0]),
    .instr_o       (instr[0]),
    .op_code_o     (opc[0]),
    .func_o        (func[0]),
    .pc_o          (pc[0]),
    .pc_plus4_o    (pcp4[0]),
    .pc_src_i      (pc_src[0])
  );

  instr_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (req[1]),
    .imem_addr_o   (addr[1]),
    .imem_ack_i    (ack[1]),
    .imem_rdata_i  (rdata[1]),
    .instr_valid_o (valid[1]),
    .instr_ready_i (ready[1]),
    .instr_o       (instr[1]),
    .op_code_o     (opc[1]),
    .func_o        (func[1]),
    .pc_o          (pc[1]),
    .pc_plus4_o    (pcp4[1]),
    .pc_src_i      (pc_src[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Bounded wait (at negedges) for imem_req on instance d.
  task automatic wait_req(input int d, input string tag);
    for (int i = 0; i < 16; i++) begin
      if (req[d] === 1'b1) return;
      @(negedge clk);
    end
    check_eq({tag, "_req_timeout"}, 32'(req[d]), 32'd1);
  endtask

  // One zero-wait fetch + immediate retire; checks held outputs and next address.
  task automatic fetch(input int d, input string tag, input logic [31:0] a,
                       input logic [31:0] w, input logic take, input logic [31:0] nxt);
    wait_req(d, tag);
    check_eq({tag, "_addr"}, addr[d], a);
    ack[d]   = 1'b1;
    rdata[d] = w;
    @(negedge clk);
    ack[d]   = 1'b0;
    rdata[d] = 32'hDEAD_BEEF;
    check_eq({tag, "_valid"}, 32'(valid[d]), 32'd1);
    check_eq({tag, "_req_lo"}, 32'(req[d]), 32'd0);
    check_eq({tag, "_instr"}, instr[d], w);
    check_eq({tag, "_opc"}, 32'(opc[d]), 32'(w[31:26]));
    check_eq({tag, "_func"}, 32'(func[d]), 32'(w[5:0]));
    check_eq({tag, "_pc"}, pc[d], a);
    check_eq({tag, "_pcp4"}, pcp4[d], a + 32'd4);
    ready[d]  = 1'b1;
    pc_src[d] = take;
    @(negedge clk);
    ready[d]  = 1'b0;
    pc_src[d] = 1'b0;
    check_eq({tag, "_valid_lo"}, 32'(valid[d]), 32'd0);
    check_eq({tag, "_req_hi"}, 32'(req[d]), 32'd1);
    check_eq({tag, "_next"}, addr[d], nxt);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ack[d] = 1'b0; rdata[d] = '0; ready[d] = 1'b0; pc_src[d] = 1'b0;
    end

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_req", 32'(req[0]), 32'd0);
    check_eq("rst_valid", 32'(valid[0]), 32'd0);
    check_eq("rst_addr", addr[0], 32'h0);
    check_eq("rst_instr", instr[0], 32'h0);
    check_eq("rst_addr_wrap", addr[1], 32'hFFFF_FFFC);
    rst_n = 1'b1;
    check_eq("rel_req", 32'(req[0]), 32'd0);
    @(negedge clk);
    check_eq("first_req", 32'(req[0]), 32'd1);
    check_eq("first_addr", addr[0], 32'h0);
    check_eq("first_valid", 32'(valid[0]), 32'd0);

    // Sequential, zero-wait: 0x0, 0x4, 0x8, 0xC
    fetch(0, "seq0", 32'h0, 32'h2008_0005, 1'b0, 32'h4);
    fetch(0, "seq1", 32'h4, 32'h0109_5020, 1'b0, 32'h8);
    fetch(0, "seq2", 32'h8, 32'h8D2A_0010, 1'b0, 32'hC);
    fetch(0, "seq3", 32'hC, 32'hAD2A_0014, 1'b0, 32'h10);

    // BEQ offset -2 at 0x10: taken -> 0x14 - 8 = 0xC
    fetch(0, "beq_t", 32'h10, 32'h1000_FFFE, 1'b1, 32'hC);
    fetch(0, "seq4", 32'hC, 32'h0000_0000, 1'b0, 32'h10);
    // Same BEQ not taken -> 0x14
    fetch(0, "beq_n", 32'h10, 32'h1000_FFFE, 1'b0, 32'h14);

    // Wait states at 0x14: no ack for 3 cycles, pc_src toggled outside retire
    pc_src[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("wait_req", 32'(req[0]), 32'd1);
      check_eq("wait_addr", addr[0], 32'h14);
      check_eq("wait_valid", 32'(valid[0]), 32'd0);
    end
    ack[0]   = 1'b1;
    rdata[0] = 32'h1000_0003;
    @(negedge clk);
    // Backpressure: 4 cycles not ready, stray ack + pc_src must be ignored
    rdata[0] = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_valid", 32'(valid[0]), 32'd1);
      check_eq("bp_instr", instr[0], 32'h1000_0003);
      check_eq("bp_pc", pc[0], 32'h14);
      check_eq("bp_req", 32'(req[0]), 32'd0);
      @(negedge clk);
    end
    ack[0]    = 1'b0;
    pc_src[0] = 1'b0;
    ready[0]  = 1'b1;
    @(negedge clk);
    ready[0] = 1'b0;
    check_eq("bp_retire_next", addr[0], 32'h18);
    check_eq("bp_retire_valid", 32'(valid[0]), 32'd0);
    @(negedge clk);
    // Still waiting in REQ: no second retire happened
    check_eq("bp_one_retire", addr[0], 32'h18);
    check_eq("bp_no_valid", 32'(valid[0]), 32'd0);

    // Branch-to-self: offset 0xFFFF taken -> 0x1C - 4 = 0x18
    fetch(0, "self", 32'h18, 32'h1000_FFFF, 1'b1, 32'h18);

    // Reset mid-REQ, ack asserted in the release cycle
    check_eq("mreq_pre", 32'(req[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mreq_req_drop", 32'(req[0]), 32'd0);
    check_eq("mreq_addr", addr[0], 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    ack[0]   = 1'b1;
    rdata[0] = 32'hCAFE_F00D;
    @(negedge clk);
    ack[0] = 1'b0;
    check_eq("mreq_valid", 32'(valid[0]), 32'd0);
    check_eq("mreq_req", 32'(req[0]), 32'd1);
    check_eq("mreq_restart", addr[0], 32'h0);
    @(negedge clk);
    check_eq("mreq_valid2", 32'(valid[0]), 32'd0);
    check_eq("mreq_instr", instr[0], 32'h0);

    // Reset during VALID
    ack[0]   = 1'b1;
    rdata[0] = 32'h2008_0001;
    @(negedge clk);
    ack[0] = 1'b0;
    check_eq("mval_pre", 32'(valid[0]), 32'd1);
    ready[0] = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_eq("mval_valid_drop", 32'(valid[0]), 32'd0);
    @(negedge clk);
    ready[0] = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check_eq("mval_no_retire", addr[0], 32'h0);

    // Wrap instance: 0xFFFFFFFC sequential -> 0x0
    wait_req(1, "wrap");
    check_eq("wrap_pcp4", pcp4[1], 32'h0);
    fetch(1, "wrap_seq", 32'hFFFF_FFFC, 32'h0000_0020, 1'b0, 32'h0);
    // Negative branch below 0: 0x4 + (-3<<2) = 0xFFFFFFF8
    fetch(1, "wrap_neg", 32'h0, 32'h1000_FFFD, 1'b1, 32'hFFFF_FFF8);
    // Offset 1 taken from 0xFFFFFFF8: 0xFFFFFFFC + 4 wraps to 0x0
    fetch(1, "wrap_t1", 32'hFFFF_FFF8, 32'h1000_0001, 1'b1, 32'h0);
    // Offset 2 taken from 0x0: 0x4 + 8 = 0xC
    fetch(1, "wrap_t2", 32'h0, 32'h1000_0002, 1'b1, 32'hC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
